// File: rtl/irq_encoder_8to3.sv
// 8-to-3 interrupt request encoder: sticky pending register, one grant per handshake.
// Define IRQ_ENCODER_ROUND_ROBIN_EN to replace fixed lowest-index priority with round-robin.
module irq_encoder_8to3 #(
    parameter int EDGE_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pend
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic [7:0] req_q;
    logic       rst_q;
    logic [7:0] events;
    logic [7:0] clr_mask;
    logic [7:0] cand;
    logic [2:0] start;
    logic [2:0] sel;
    logic       hs;

    // First set bit of vec searching upward (with wrap) from start.
    function automatic logic [2:0] pick_from(input logic [7:0] vec, input logic [2:0] start_pos);
        logic [2:0] pos;
        pick_from = start_pos;
        for (int k = 7; k >= 0; k--) begin
            pos = start_pos + 3'(k);
            if (vec[pos]) pick_from = pos;
        end
    endfunction

    assign hs = valid_q & ready;

`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;

    always_comb begin
        start = hs ? idx_q + 3'd1 : ptr_q;
        ptr_d = (en && hs) ? idx_q + 3'd1 : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 3'd0;
        else     ptr_q <= ptr_d;
    end
`else
    assign start = 3'd0;
`endif

    always_comb begin
        // rst_q masks the first edge after reset so a level held across release is not an edge.
        events   = (EDGE_MODE != 0) ? (req & ~req_q & {8{~rst_q}}) : req;
        clr_mask = hs ? (8'b1 << idx_q) : 8'h00;
        cand     = (state_q == PRESENT) ? (pend_q & ~clr_mask) : pend_q;
        sel      = pick_from(cand, start);

        state_d  = state_q;
        pend_d   = pend_q;
        idx_d    = idx_q;
        valid_d  = valid_q;

        if (!en) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            pend_d = (pend_q & ~clr_mask) | events;
            case (state_q)
                IDLE: begin
                    if (pend_q != 8'h00) begin
                        idx_d   = sel;
                        valid_d = 1'b1;
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    if (hs) begin
                        if (cand != 8'h00) begin
                            idx_d = sel;
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 8'h00;
            req_q   <= 8'h00;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            req_q   <= req;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            rst_q   <= 1'b0;
        end
    end

    assign idx   = idx_q;
    assign valid = valid_q;
    assign pend  = pend_q;

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Bench for irq_encoder_8to3: level and edge instances against a behavioural model,
// directed scenarios plus randomized traffic.
module tb_irq_encoder_8to3;

`ifdef IRQ_ENCODER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       ready;
    logic [2:0] idx0, idx1;
    logic       valid0, valid1;
    logic [7:0] pend0, pend1;

    int tests;
    int fails;

    irq_encoder_8to3 #(.EDGE_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .idx(idx0), .valid(valid0), .ready(ready), .pend(pend0)
    );

    irq_encoder_8to3 #(.EDGE_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .idx(idx1), .valid(valid1), .ready(ready), .pend(pend1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model, index 0 = level capture, 1 = edge capture.
    logic [7:0] m_pend [2];
    int         m_idx  [2];
    bit         m_valid[2];
    logic [7:0] m_prev [2];
    bit         m_fresh[2];
    int         m_ptr  [2];

    int g0[$];
    int g1[$];

    function automatic int choose(input logic [7:0] set, input int from);
        for (int k = 0; k < 8; k++) begin
            if (set[(from + k) % 8]) return (from + k) % 8;
        end
        return 0;
    endfunction

    task automatic model_update(input int m, input logic r, input logic e,
                                input logic [7:0] q, input logic y);
        logic [7:0] ev;
        logic [7:0] remaining;
        int         granted;
        if (r) begin
            m_pend[m] = 8'h00; m_idx[m] = 0; m_valid[m] = 1'b0;
            m_prev[m] = 8'h00; m_fresh[m] = 1'b1; m_ptr[m] = 0;
            return;
        end
        if (m == 0) ev = q;
        else        ev = m_fresh[m] ? 8'h00 : (q & ~m_prev[m]);
        m_prev[m]  = q;
        m_fresh[m] = 1'b0;
        if (!e) begin
            m_valid[m] = 1'b0;
            return;
        end
        if (m_valid[m] && y) begin
            granted   = m_idx[m];
            remaining = m_pend[m];
            remaining[granted] = 1'b0;
            m_ptr[m]  = (granted + 1) % 8;
            if (remaining != 8'h00) m_idx[m] = choose(remaining, RR ? m_ptr[m] : 0);
            else                    m_valid[m] = 1'b0;
            m_pend[m] = remaining | ev;
        end else begin
            if (!m_valid[m] && m_pend[m] != 8'h00) begin
                m_idx[m]   = choose(m_pend[m], RR ? m_ptr[m] : 0);
                m_valid[m] = 1'b1;
            end
            m_pend[m] = m_pend[m] | ev;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        check("m0_idx",   32'(idx0),   32'(m_idx[0]));
        check("m0_valid", 32'(valid0), 32'(m_valid[0]));
        check("m0_pend",  32'(pend0),  32'(m_pend[0]));
        check("m1_idx",   32'(idx1),   32'(m_idx[1]));
        check("m1_valid", 32'(valid1), 32'(m_valid[1]));
        check("m1_pend",  32'(pend1),  32'(m_pend[1]));
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] q, input logic y);
        rst = r; en = e; req = q; ready = y;
        if (!r && e && valid0 === 1'b1 && y) g0.push_back(int'(idx0));
        if (!r && e && valid1 === 1'b1 && y) g1.push_back(int'(idx1));
        @(posedge clk);
        model_update(0, r, e, q, y);
        model_update(1, r, e, q, y);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; en = 1'b0; req = 8'h00; ready = 1'b0;

        step(1'b1, 1'b0, 8'hff, 1'b1);
        step(1'b1, 1'b1, 8'hff, 1'b1);
        check("rst_pend",  32'(pend0),  32'h00);
        check("rst_valid", 32'(valid0), 32'h0);
        check("rst_idx",   32'(idx0),   32'h0);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // Two-source burst, back-to-back grants
        step(1'b0, 1'b1, 8'h24, 1'b1);
        check("burst_pend_capt", 32'(pend0), 32'h24);
        check("burst_valid_lat", 32'(valid0), 32'h0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check("burst_valid1", 32'(valid0), 32'h1);
        check("burst_idx2",   32'(idx0),   32'h2);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check("burst_idx5",   32'(idx0),   32'h5);
        check("burst_valid2", 32'(valid0), 32'h1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check("burst_done_valid", 32'(valid0), 32'h0);
        check("burst_done_pend",  32'(pend0),  32'h00);

        // Stalled consumer holds the presentation
        do_reset();
        step(1'b0, 1'b1, 8'h81, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            check("stall_idx",   32'(idx0),   32'h0);
            check("stall_valid", 32'(valid0), 32'h1);
        end
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check("stall_next_idx", 32'(idx0), 32'h7);

        // Held level on the granted bit: set wins, bit is re-presented after one gap cycle
        do_reset();
        step(1'b0, 1'b1, 8'h08, 1'b0);
        step(1'b0, 1'b1, 8'h08, 1'b0);
        check("hold_idx3", 32'(idx0), 32'h3);
        step(1'b0, 1'b1, 8'h08, 1'b1);
        check("hold_pend3", 32'(pend0[3]), 32'h1);
        step(1'b0, 1'b1, 8'h08, 1'b1);
        check("hold_repres_valid", 32'(valid0), 32'h1);
        check("hold_repres_idx",   32'(idx0),   32'h3);

        // Edge capture of a long level yields exactly one grant
        do_reset();
        g1.delete();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, 8'h00, 1'b1);
        check("edge_grants", 32'(g1.size()), 32'd1);
        if (g1.size() > 0) check("edge_grant_idx", 32'(g1[0]), 32'd0);

        // Edge mode: level held across reset release is not an event
        step(1'b1, 1'b0, 8'h40, 1'b0);
        step(1'b0, 1'b1, 8'h40, 1'b0);
        step(1'b0, 1'b1, 8'h40, 1'b0);
        check("edge_rst_pend", 32'(pend1), 32'h00);

        // Disable pauses presentation, keeps pend; reset mid-presentation clears all
        do_reset();
        step(1'b0, 1'b1, 8'h10, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("en_pre_idx", 32'(idx0), 32'h4);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("en_off_valid", 32'(valid0),  32'h0);
        check("en_off_pend4", 32'(pend0[4]), 32'h1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("en_on_valid", 32'(valid0), 32'h1);
        check("en_on_idx",   32'(idx0),   32'h4);
        step(1'b1, 1'b1, 8'h00, 1'b1);
        check("mid_rst_zero", {29'd0, idx0} | {31'd0, valid0} | {24'd0, pend0}, 32'h0);

        // Two held sources: exclusion of the cleared bit alternates grants in both priority schemes
        do_reset();
        step(1'b0, 1'b1, 8'h03, 1'b0);
        g0.delete();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h03, 1'b1);
        check("alt_count", 32'(g0.size() >= 4), 32'h1);
        if (g0.size() >= 4) begin
            check("alt_g0", 32'(g0[0]), 32'd0);
            check("alt_g1", 32'(g0[1]), 32'd1);
            check("alt_g2", 32'(g0[2]), 32'd0);
            check("alt_g3", 32'(g0[3]), 32'd1);
        end

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                 8'($urandom & $urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
